// File: rtl/bram_loader_pkg.sv
// Shared definitions for the BRAM loaders: the lane count macro that the
// engine and both loader instances agree on, plus the common field widths.
`ifndef BURST_LEN
`define BURST_LEN 8
`endif

package bram_loader_pkg;
  localparam int HW_W  = 16;
  localparam int LEN_W = 16;
endpackage

// File: rtl/bram_loader.sv
// Packs a stream of 16-bit halfwords into BURST_LEN-lane RAM words and
// writes them to consecutive addresses starting at a latched base.
`ifndef BURST_LEN
`define BURST_LEN 8
`endif

module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int BURST_LEN = `BURST_LEN,
  parameter int ADDR_W    = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LEN_W-1:0]          load_len,
  input  logic                      in_valid,
  input  logic [31:0]               in_data,
  output logic                      in_ready,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [HW_W*BURST_LEN-1:0] ram_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [ADDR_W:0]           words_written
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DATA_W = HW_W * BURST_LEN;
  localparam int LANE_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BURST_LEN - 1);

  logic [2:0]        state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              ram_we_q, ram_we_d;
  logic              overflow_q, overflow_d;

  logic              accept;
  logic              shift;
  logic [HW_W-1:0]   shift_hw;
  logic              unused_in_hi;

  assign unused_in_hi = ^in_data[31:16];
  assign accept       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      remaining_q <= '0;
      ram_data_q  <= '0;
      ram_addr_q  <= '0;
      words_q     <= '0;
      ram_we_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      remaining_q <= remaining_d;
      ram_data_q  <= ram_data_d;
      ram_addr_q  <= ram_addr_d;
      words_q     <= words_d;
      ram_we_q    <= ram_we_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = (load_len == '0) ? S_DONE : S_FILL;
        S_FILL:  if (accept && remaining_q == LEN_W'(1))
                   state_d = (lane_q == LANE_LAST) ? S_LAST : S_FLUSH;
        S_FLUSH: if (lane_q == LANE_LAST) state_d = S_LAST;
        S_LAST:  if (!ram_we_q) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lane_d      = lane_q;
    remaining_d = remaining_q;
    ram_data_d  = ram_data_q;
    ram_addr_d  = ram_addr_q;
    words_d     = words_q;
    overflow_d  = overflow_q;
    ram_we_d    = 1'b0;
    shift       = 1'b0;
    shift_hw    = '0;

    // The write happens with the current address; step it as the strobe ends.
    if (ram_we_q) begin
      ram_addr_d = ram_addr_q + 1'b1;
      words_d    = words_q + 1'b1;
      if (ram_addr_q == '1) overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ram_addr_d  = base_addr;
          remaining_d = load_len;
          lane_d      = '0;
          ram_data_d  = '0;
          words_d     = '0;
          overflow_d  = 1'b0;
        end
      end
      S_FILL: begin
        if (accept) begin
          shift       = 1'b1;
          shift_hw    = in_data[HW_W-1:0];
          remaining_d = remaining_q - 1'b1;
        end
      end
      S_FLUSH: shift = 1'b1;
      default: ;
    endcase

    if (shift) begin
      ram_data_d = {shift_hw, ram_data_q[DATA_W-1:HW_W]};
      if (lane_q == LANE_LAST) begin
        lane_d   = '0;
        ram_we_d = 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end

    if (clr) begin
      lane_d      = '0;
      remaining_d = '0;
      ram_data_d  = '0;
      ram_addr_d  = '0;
      words_d     = '0;
      overflow_d  = 1'b0;
      ram_we_d    = 1'b0;
    end
  end

  always_comb begin
    in_ready      = (state_q == S_FILL) && (remaining_q != '0);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    ram_we        = ram_we_q;
    ram_addr      = ram_addr_q;
    ram_data      = ram_data_q;
    overflow      = overflow_q;
    words_written = words_q;
  end

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: drives loads, records RAM writes and checks
// packed words, addresses, flush timing, overflow and clear behaviour.
module tb_bram_loader;
  localparam int AW = 10;
  localparam int BL = 8;
  localparam int DW = 16 * BL;

  localparam logic [DW-1:0] W_LO   = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [DW-1:0] W_HI   = 128'h0010_000f_000e_000d_000c_000b_000a_0009;
  localparam logic [DW-1:0] W_TAIL = 128'h0000_0000_0000_0000_0000_0000_000a_0009;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   load_len = '0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW:0]   words_written;

  int n_tests = 0;
  int n_fail  = 0;

  int            cyc = 0;
  int            last_acc = 0;
  int            done_cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_cyc[$];

  bram_loader #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
    .base_addr(base_addr), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .busy(busy), .done(done), .overflow(overflow),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (ram_we) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_data);
      wr_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) last_acc = cyc;
    if (done) done_cyc = cyc;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b1; base_addr = b; load_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds halfwords first..first+n-1; in toggle mode valid alternates with junk idles.
  task automatic stream(input string tag, input int n, input bit toggle, input int first);
    int k = 0;
    int guard = 0;
    bit ph = 1'b1;
    while (k < n && guard < 300) begin
      @(posedge clk); #1;
      in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      in_data = in_valid ? {16'hA5A5, 16'(first + k)} : 32'h0000_BEEF;
      @(negedge clk);
      if (in_valid && in_ready) k++;
      guard++;
    end
    chk({tag, "_accepts"}, k, n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    @(negedge clk);
    while (!done && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_data"}, ram_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_words"}, words_written, 0);
  endtask

  initial begin
    // Reset state, and no spurious strobes after release
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rel_we_done_busy", {ram_we, done, busy}, 3'b000);
    end

    // Back-to-back load of 16 halfwords at base 0
    clear_log();
    do_start(10'd0, 16'd16);
    stream("s1", 16, 1'b0, 1);
    wait_done("s1");
    chk("s1_nwr", wr_addr.size(), 2);
    chk("s1_addr0", wr_addr[0], 0);
    chk("s1_addr1", wr_addr[1], 1);
    chk("s1_word0", wr_data[0], W_LO);
    chk("s1_word1", wr_data[1], W_HI);
    chk("s1_tput", wr_cyc[1] - wr_cyc[0], 8);
    chk("s1_we_after_acc", wr_cyc[1] - last_acc, 1);
    chk("s1_done_gap", done_cyc - wr_cyc[1], 2);
    chk("s1_words", words_written, 2);
    chk("s1_ovf", overflow, 0);

    // Partial final word at base 5; junk beats offered during flush
    clear_log();
    do_start(10'd5, 16'd10);
    stream("s2", 10, 1'b0, 1);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_BEEF;
    wait_done("s2");
    chk("s2_nwr", wr_addr.size(), 2);
    chk("s2_addr0", wr_addr[0], 5);
    chk("s2_addr1", wr_addr[1], 6);
    chk("s2_word0", wr_data[0], W_LO);
    chk("s2_word1", wr_data[1], W_TAIL);
    chk("s2_flush_gap", wr_cyc[1] - last_acc, 7);
    chk("s2_words", words_written, 2);

    // Valid toggling every other cycle gives the same RAM contents
    clear_log();
    do_start(10'd0, 16'd16);
    stream("s3", 16, 1'b1, 1);
    wait_done("s3");
    chk("s3_nwr", wr_addr.size(), 2);
    chk("s3_addr0", wr_addr[0], 0);
    chk("s3_addr1", wr_addr[1], 1);
    chk("s3_word0", wr_data[0], W_LO);
    chk("s3_word1", wr_data[1], W_HI);

    // Address wrap from 1023 sets overflow; next start clears it
    clear_log();
    do_start(10'd1023, 16'd16);
    stream("s4", 16, 1'b0, 1);
    wait_done("s4");
    chk("s4_addr0", wr_addr[0], 1023);
    chk("s4_addr1", wr_addr[1], 0);
    chk("s4_word1", wr_data[1], W_HI);
    chk("s4_ovf_set", overflow, 1);
    chk("s4_words", words_written, 2);
    do_start(10'd0, 16'd0);
    chk("s4_ovf_clr", overflow, 0);
    wait_done("s4b");

    // Clear after 11 accepts, then a fresh load
    clear_log();
    do_start(10'd2, 16'd16);
    stream("s5", 11, 1'b0, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk_zero("s5_clr");
    in_valid = 1'b1;
    in_data  = 32'h0000_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s5_no_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("s5_nwr_before", wr_addr.size(), 1);
    chk("s5_addr_before", wr_addr[0], 2);
    clear_log();
    do_start(10'd0, 16'd16);
    stream("s5b", 16, 1'b0, 1);
    wait_done("s5b");
    chk("s5b_nwr", wr_addr.size(), 2);
    chk("s5b_word0", wr_data[0], W_LO);
    chk("s5b_word1", wr_data[1], W_HI);

    // Zero-length load: done one cycle after start, no writes
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd7; load_len = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("s6_done", done, 1);
    chk("s6_busy", busy, 1);
    @(posedge clk); #1;
    chk("s6_done_end", done, 0);
    chk("s6_idle", busy, 0);
    chk("s6_nwr", wr_addr.size(), 0);

    // A start pulse mid-load is ignored
    clear_log();
    do_start(10'd0, 16'd16);
    stream("s7a", 5, 1'b0, 1);
    start = 1'b1; base_addr = 10'd300; load_len = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("s7_still_busy", busy, 1);
    stream("s7b", 11, 1'b0, 6);
    wait_done("s7");
    chk("s7_nwr", wr_addr.size(), 2);
    chk("s7_addr0", wr_addr[0], 0);
    chk("s7_addr1", wr_addr[1], 1);
    chk("s7_word0", wr_data[0], W_LO);
    chk("s7_word1", wr_data[1], W_HI);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
